mult_accumulator: RTL and testbench

Sequential accumulate stage that sits directly downstream of `unsigned_array_mult`. It consumes the 12-bit unsigned `product` through a valid/ready handshake and sums a fixed number of products (`COUNT`) into a saturating accumulator. It then presents the total on a valid/ready output port and holds it until the output is taken. The block turns the combinational multiplier into a multiply-accumulate datapath for dot-product style sequences.

---
 rtl/mult_accumulator_if.sv | 31 +++
 rtl/mult_accumulator.sv | 95 +++++++++
 tb/tb_mult_accumulator.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_accumulator_if.sv
// Purpose: groups the product input stream, result output stream and clear into one bundle for the accumulator.
// Latency: none; this is wiring only.
// Backpressure: valid/ready on both streams, with ready driven by the receiving side.
interface mult_accumulator_if #(
    parameter int PROD_W = 12,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4,
    parameter int CNT_W  = $clog2(COUNT + 1)
) ();
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    // The producer/consumer side drives the products and consumes the results.
    modport master (
        output clear, in_valid, product, out_ready,
        input  in_ready, out_valid, sum, overflow, count
    );

    // The accumulator side.
    modport slave (
        input  clear, in_valid, product, out_ready,
        output in_ready, out_valid, sum, overflow, count
    );
endinterface

// File: rtl/mult_accumulator.sv
// Purpose: sums COUNT unsigned products into a saturating accumulator and presents the total as a held result.
// Latency: sum updates on the edge that accepts a beat; out_valid rises on the edge that accepts the COUNT-th beat.
// Backpressure: the result is held indefinitely until out_ready; no input is accepted while the result is held.
module mult_accumulator #(
    parameter  int PROD_W = 12,
    parameter  int ACC_W  = 16,
    parameter  int COUNT  = 4,
    localparam int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mult_accumulator_if.slave   mac_if
);
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] SUM_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    // One extra bit above the accumulator catches the carry that signals saturation.
    logic [ACC_W:0]    add_full;
    assign add_full = {1'b0, sum_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, mac_if.product};

    // Next-state: clear wins over everything; ACCUM adds accepted beats, DONE waits for the handshake.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (mac_if.clear) begin
            state_d = ST_ACCUM;
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (mac_if.in_valid) begin
                        // Adding a non-negative value to the maximum carries again, so saturation sticks.
                        if (add_full[ACC_W]) begin
                            sum_d = SUM_MAX;
                            ovf_d = 1'b1;
                        end else begin
                            sum_d = add_full[ACC_W-1:0];
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (mac_if.out_ready) begin
                        state_d = ST_ACCUM;
                        sum_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ACCUM;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs come straight from the state register, with no path from in_valid/out_ready.
    assign mac_if.in_ready  = (state_q == ST_ACCUM);
    assign mac_if.out_valid = (state_q == ST_DONE);
    assign mac_if.sum       = sum_q;
    assign mac_if.overflow  = ovf_q;
    assign mac_if.count     = cnt_q;
endmodule

// File: tb/tb_mult_accumulator.sv
// Purpose: drives identical stimulus into a 16-bit and a 12-bit accumulator and checks them against a group-level model.
// Latency: state is checked 1 time unit after each rising edge; results are checked when the handshake is seen.
// Backpressure: out_ready is driven both in directed stall patterns and at random.
module tb_mult_accumulator;
    localparam int COUNT = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        clear     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] product   = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_accumulator_if #(.PROD_W(12), .ACC_W(16), .COUNT(COUNT)) bus0 ();
    mult_accumulator_if #(.PROD_W(12), .ACC_W(12), .COUNT(COUNT)) bus1 ();

    assign bus0.clear     = clear;
    assign bus0.in_valid  = in_valid;
    assign bus0.product   = product;
    assign bus0.out_ready = out_ready;
    assign bus1.clear     = clear;
    assign bus1.in_valid  = in_valid;
    assign bus1.product   = product;
    assign bus1.out_ready = out_ready;

    mult_accumulator #(.PROD_W(12), .ACC_W(16), .COUNT(COUNT)) dut0 (
        .clk_i  (clk),
        .rst_i  (rst),
        .mac_if (bus0)
    );

    mult_accumulator #(.PROD_W(12), .ACC_W(12), .COUNT(COUNT)) dut1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .mac_if (bus1)
    );

    // Group-level reference: true (unbounded) total and beat count per group, per instance.
    typedef struct {
        longint s;
        bit     o;
    } res_t;

    longint tsum [2];
    int     nbeat[2];
    bit     done [2];
    longint maxv [2];
    res_t   q0[$];
    res_t   q1[$];

    task automatic cmp(input string name, input logic [63:0] act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint sat_of(int k);
        return (tsum[k] > maxv[k]) ? maxv[k] : tsum[k];
    endfunction

    function automatic void drop_pending(int k);
        if (k == 0 && q0.size() > 0) void'(q0.pop_back());
        if (k == 1 && q1.size() > 0) void'(q1.pop_back());
    endfunction

    function automatic void model_reset(int k);
        if (done[k]) drop_pending(k);
        tsum[k]  = 0;
        nbeat[k] = 0;
        done[k]  = 1'b0;
    endfunction

    // Applies one clock edge worth of the rules to the model using the inputs held across that edge.
    function automatic void model_tick(int k);
        res_t r;
        if (clear) begin
            model_reset(k);
        end else if (!done[k] && in_valid) begin
            tsum[k]  += longint'(product);
            nbeat[k] += 1;
            if (nbeat[k] == COUNT) begin
                done[k] = 1'b1;
                r.s = sat_of(k);
                r.o = (tsum[k] > maxv[k]);
                if (k == 0) q0.push_back(r);
                else        q1.push_back(r);
            end
        end else if (done[k] && out_ready) begin
            tsum[k]  = 0;
            nbeat[k] = 0;
            done[k]  = 1'b0;
        end
    endfunction

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("%s.sum%0d", tag, k),   k ? 64'(bus1.sum)      : 64'(bus0.sum),      sat_of(k));
            cmp($sformatf("%s.ovf%0d", tag, k),   k ? 64'(bus1.overflow) : 64'(bus0.overflow), longint'(tsum[k] > maxv[k]));
            cmp($sformatf("%s.cnt%0d", tag, k),   k ? 64'(bus1.count)    : 64'(bus0.count),    longint'(nbeat[k]));
            cmp($sformatf("%s.ordy%0d", tag, k),  k ? 64'(bus1.in_ready) : 64'(bus0.in_ready), longint'(!done[k]));
            cmp($sformatf("%s.ovld%0d", tag, k),  k ? 64'(bus1.out_valid): 64'(bus0.out_valid),longint'(done[k]));
        end
    endtask

    task automatic step(input logic v, input int p, input logic ordy, input logic clr, input string tag);
        in_valid  = v;
        product   = 12'(p);
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        model_tick(0);
        model_tick(1);
        #1;
        check_state(tag);
    endtask

    // Reset is pulsed between edges; outputs must already be cleared before the next edge.
    task automatic async_reset(input string tag);
        #1;
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_state(tag);
        rst = 1'b0;
    endtask

    // Result monitor: compares every completed handshake with the oldest expected result.
    res_t m0, m1;
    always @(negedge clk) begin
        if (!rst && !clear && out_ready) begin
            if (bus0.out_valid) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result0 unexpected actual %0d required none", bus0.sum);
                end else begin
                    m0 = q0.pop_front();
                    cmp("result0.sum", 64'(bus0.sum), m0.s);
                    cmp("result0.ovf", 64'(bus0.overflow), longint'(m0.o));
                end
            end
            if (bus1.out_valid) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result1 unexpected actual %0d required none", bus1.sum);
                end else begin
                    m1 = q1.pop_front();
                    cmp("result1.sum", 64'(bus1.sum), m1.s);
                    cmp("result1.ovf", 64'(bus1.overflow), longint'(m1.o));
                end
            end
        end
    end

    int basic_p[4] = '{7, 3969, 288, 138};
    int gap_p[4]   = '{12, 138, 2178, 66};

    initial begin
        maxv[0] = 65535;
        maxv[1] = 4095;
        for (int k = 0; k < 2; k++) begin
            tsum[k] = 0; nbeat[k] = 0; done[k] = 1'b0;
        end

        #2;
        check_state("por");
        #1;
        rst = 1'b0;

        // Basic group, one beat per cycle.
        for (int i = 0; i < 4; i++) step(1'b1, basic_p[i], 1'b0, 1'b0, "basic");
        cmp("basic_total", 64'(bus0.sum), 4402);
        step(1'b0, 0, 1'b1, 1'b0, "basic_take");

        // Saturation on the narrow instance, then a fresh group must start unsaturated.
        step(1'b1, 3969, 1'b0, 1'b0, "sat");
        step(1'b1, 3969, 1'b0, 1'b0, "sat");
        cmp("sat_second", 64'(bus1.sum), 4095);
        step(1'b1, 1, 1'b0, 1'b0, "sat");
        step(1'b1, 1, 1'b0, 1'b0, "sat");
        cmp("sat_total", 64'(bus1.sum), 4095);
        cmp("sat_flag", 64'(bus1.overflow), 1);
        step(1'b0, 0, 1'b1, 1'b0, "sat_take");
        step(1'b1, 5, 1'b0, 1'b0, "sat_next");
        cmp("sat_next_flag", 64'(bus1.overflow), 0);
        step(1'b1, 5, 1'b0, 1'b0, "sat_next");
        step(1'b1, 5, 1'b0, 1'b0, "sat_next");
        step(1'b1, 5, 1'b0, 1'b0, "sat_next");
        step(1'b0, 0, 1'b1, 1'b0, "sat_next_take");

        // Gaps between beats, then a stall with a beat offered that must not count.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, gap_p[i], 1'b0, 1'b0, "gap");
            if (i < 3) begin
                step(1'b0, 999, 1'b0, 1'b0, "gap_idle");
                step(1'b0, 999, 1'b0, 1'b0, "gap_idle");
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 77, 1'b0, 1'b0, "stall");
            cmp("stall_sum", 64'(bus0.sum), 2394);
            cmp("stall_inrdy", 64'(bus0.in_ready), 0);
        end
        step(1'b0, 0, 1'b1, 1'b0, "stall_take");

        // Clear beats a simultaneous input.
        step(1'b1, 63, 1'b0, 1'b0, "clr");
        step(1'b1, 288, 1'b0, 1'b0, "clr");
        step(1'b1, 361, 1'b0, 1'b1, "clr_pulse");
        cmp("clr_sum", 64'(bus0.sum), 0);
        cmp("clr_cnt", 64'(bus0.count), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0, "clr_fresh");
        cmp("clr_fresh_total", 64'(bus0.sum), 4);
        // Clear also beats a simultaneous result handshake.
        step(1'b0, 0, 1'b1, 1'b1, "clr_done");

        // Asynchronous reset mid-group and while holding a result.
        for (int i = 0; i < 3; i++) step(1'b1, 500, 1'b0, 1'b0, "arst");
        async_reset("arst_mid");
        step(1'b1, 9, 1'b0, 1'b0, "arst_after");
        for (int i = 0; i < 3; i++) step(1'b1, 500, 1'b0, 1'b0, "arst");
        async_reset("arst_done");
        cmp("arst_done_inrdy", 64'(bus0.in_ready), 1);

        // Back-to-back groups with out_ready high and a continuously held beat.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 360, 1'b1, 1'b0, "b2b");
            if (i == 3 || i == 8) cmp("b2b_total", 64'(bus0.sum), 1440);
            if (i == 4) cmp("b2b_gap_cnt", 64'(bus0.count), 0);
        end
        step(1'b0, 0, 1'b1, 1'b0, "b2b_take");

        // Random traffic, biased toward large products so the narrow instance saturates often.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(3000, 4095)),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 31) == 0),
                 "rnd");
            if ($urandom_range(0, 63) == 0) async_reset("rnd_rst");
        end

        // Drain so every expected result has been seen.
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, "drain");
        cmp("left0", 64'(q0.size()), 0);
        cmp("left1", 64'(q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
